gravador_sequencia: RTL and testbench
=====================================

Name: gravador_sequencia

Overview:
- Writer end of the game memory. The player enters a sequence of values on chaves, one per jogada button press, and the block stores them in an internal N_ENDERECOS x 4 RAM.
- The comparison side (game datapath/UC) later reads the same RAM through an independent asynchronous read port.
- Contains its own FSM, address counter, data register and button edge detector.
- Debug outputs feed hexa7seg displays at the top level.

Parameters:
- N_ENDERECOS, 16, number of RAM positions (power of 2, max 16).
- LARGURA, 4, data width of chaves and RAM words.

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-low; reset==0 at a rising edge forces reset
- iniciar  input  1  level; starts a recording session
- jogada  input  1  raw button level; internally rising-edge detected
- chaves  input  4  value to record
- ler_endereco  input  4  read address from the comparison side
- dado_lido  output  4  RAM[ler_endereco], combinational read
- pronto  output  1  high in state FIM
- gravando  output  1  high in ESPERA, REGISTRA, GRAVA, PROXIMO
- escreve  output  1  RAM write enable, high only in GRAVA
- db_endereco  output  4  current write address
- db_dado  output  4  contents of data register
- db_estado  output  4  state code

Behaviour:
- Reset (reset==0 at an edge):
  - state INICIAL, write address 0, data register 0, edge-detector history 0.
  - pronto, gravando and escreve are 0.
  - RAM contents are NOT cleared; dado_lido keeps reflecting stored data.
  - Reset has priority over every other input, including mid-session.
- Edge detector: jogada_ant <= jogada every cycle in all states. pulso = jogada & ~jogada_ant.
- State codes: INICIAL=0, PREPARACAO=1, ESPERA=2, REGISTRA=3, GRAVA=4, PROXIMO=5, FIM=F. Unused codes go to INICIAL next cycle.
- INICIAL: iniciar=1 -> PREPARACAO; otherwise stay.
- PREPARACAO: zeros the address and data register, then -> ESPERA unconditionally.
- ESPERA:
  - pulso=1 and chaves!=0 -> REGISTRA.
  - pulso with chaves==0 is ignored; stay in ESPERA.
- REGISTRA: data register <= chaves, sampled at the edge leaving REGISTRA; -> GRAVA.
- GRAVA:
  - escreve=1; RAM[endereco] <= data register at the edge leaving GRAVA.
  - endereco==N_ENDERECOS-1 -> FIM; otherwise -> PROXIMO.
- PROXIMO: endereco <= endereco+1; -> ESPERA.
- FIM:
  - pronto=1, address held at N_ENDERECOS-1.
  - iniciar=1 -> PREPARACAO, i.e. a new session overwrites from address 0.
- Latency: a rising edge k with the pulse seen in ESPERA gives:
  - REGISTRA in cycle k+1.
  - GRAVA in cycle k+2, with escreve high.
  - New data on dado_lido (if ler_endereco matches) from cycle k+3.
  - ESPERA again at cycle k+4.
- Button held high for many cycles produces exactly one write. Pulses arriving outside ESPERA are discarded, not queued.
- chaves changing after REGISTRA does not affect the written value.
- iniciar is ignored in every state except INICIAL and FIM.
- Read port:
  - dado_lido is purely combinational from ler_endereco and is valid in every state.
  - Reading the address being written in GRAVA returns the old value until the edge.
- Widths: endereco is 4 bits; when N_ENDERECOS<16 the upper addresses are unused. ler_endereco >= N_ENDERECOS returns 0.

Test Plan:
- Reset: hold reset=0 two cycles -> db_estado=0, pronto=0, gravando=0, escreve=0, db_endereco=0. Preload RAM[3]=4 before reset -> dado_lido at ler_endereco=3 is still 4 after reset.
- Full session: iniciar pulse, then 16 presses with chaves=1,2,4,8,1,... -> escreve high exactly 16 single cycles, pronto=1, db_estado=F. Reading addresses 0..15 returns the pattern.
- Filtering: press with chaves=0 -> no state change, no escreve. Hold jogada high 20 cycles with chaves=2 -> exactly one write, address advances by 1.
- Timing: press at edge k with chaves=8 and ler_endereco=current address -> escreve=1 only in cycle k+2, dado_lido=8 from k+3, db_estado=2 at k+4.
- Mid-session reset: after 5 writes, reset=0 -> INICIAL, address 0. RAM[0..4] retained. A new session overwrites address 0 first.
- Restart from FIM: iniciar=1 in FIM -> PREPARACAO then ESPERA, db_endereco=0. iniciar pulses during ESPERA are ignored.

Source files
------------

// File: rtl/gravador_sequencia_if.sv
// Player-facing bus of the sequence recorder: session control, button, switches,
// comparison-side read port and debug taps for the seven-segment displays.
interface gravador_sequencia_if #(
  parameter int LARGURA = 4
);
  logic               iniciar;
  logic               jogada;
  logic [LARGURA-1:0] chaves;
  logic [3:0]         ler_endereco;
  logic [LARGURA-1:0] dado_lido;
  logic               pronto;
  logic               gravando;
  logic               escreve;
  logic [3:0]         db_endereco;
  logic [LARGURA-1:0] db_dado;
  logic [3:0]         db_estado;

  modport master (
    output iniciar, jogada, chaves, ler_endereco,
    input  dado_lido, pronto, gravando, escreve, db_endereco, db_dado, db_estado
  );

  modport slave (
    input  iniciar, jogada, chaves, ler_endereco,
    output dado_lido, pronto, gravando, escreve, db_endereco, db_dado, db_estado
  );
endinterface

// File: rtl/gravador_sequencia.sv
// Writer side of the game memory: records one switch value per button press into
// an N_ENDERECOS x LARGURA RAM that the comparison logic reads asynchronously.
module gravador_sequencia #(
  parameter int N_ENDERECOS = 16,
  parameter int LARGURA     = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  gravador_sequencia_if.slave  bus
);
  localparam int AW = (N_ENDERECOS > 1) ? $clog2(N_ENDERECOS) : 1;

  typedef enum logic [3:0] {
    INICIAL    = 4'h0,
    PREPARACAO = 4'h1,
    ESPERA     = 4'h2,
    REGISTRA   = 4'h3,
    GRAVA      = 4'h4,
    PROXIMO    = 4'h5,
    FIM        = 4'hF
  } estado_t;

  estado_t            estado, proximo;
  logic [3:0]         endereco;
  logic [LARGURA-1:0] dado;
  logic               jogada_ant;
  logic               pulso;
  logic               ultimo;
  logic               zera, registra, conta, escreve;
  logic [LARGURA-1:0] mem [N_ENDERECOS];

  assign pulso  = bus.jogada & ~jogada_ant;
  assign ultimo = (endereco == 4'(N_ENDERECOS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clock) begin
    if (!reset) estado <= INICIAL;
    else        estado <= proximo;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    proximo  = estado;
    zera     = 1'b0;
    registra = 1'b0;
    conta    = 1'b0;
    escreve  = 1'b0;
    unique case (estado)
      INICIAL:    if (bus.iniciar) proximo = PREPARACAO;
      PREPARACAO: begin
        zera    = 1'b1;
        proximo = ESPERA;
      end
      ESPERA:     if (pulso && (bus.chaves != '0)) proximo = REGISTRA;
      REGISTRA: begin
        registra = 1'b1;
        proximo  = GRAVA;
      end
      GRAVA: begin
        escreve = 1'b1;
        proximo = ultimo ? FIM : PROXIMO;
      end
      PROXIMO: begin
        conta   = 1'b1;
        proximo = ESPERA;
      end
      FIM:        if (bus.iniciar) proximo = PREPARACAO;
      default:    proximo = INICIAL;
    endcase
  end

  // Button history runs in every state so a long press yields a single pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      endereco   <= '0;
      dado       <= '0;
      jogada_ant <= 1'b0;
    end else begin
      jogada_ant <= bus.jogada;
      if (zera) begin
        endereco <= '0;
        dado     <= '0;
      end else begin
        if (registra) dado     <= bus.chaves;
        if (conta)    endereco <= endereco + 4'd1;
      end
    end
  end

  // NOTE: the RAM has no reset on purpose; recorded sequences survive a reset
  // and a plain array maps onto memory primitives.
  always_ff @(posedge clock) begin
    if (escreve) mem[endereco[AW-1:0]] <= dado;
  end

  generate
    if (N_ENDERECOS < 16) begin : g_leitura_parcial
      assign bus.dado_lido = ({1'b0, bus.ler_endereco} < 5'(N_ENDERECOS))
                             ? mem[bus.ler_endereco[AW-1:0]] : '0;
    end else begin : g_leitura_total
      assign bus.dado_lido = mem[bus.ler_endereco[AW-1:0]];
    end
  endgenerate

  assign bus.pronto      = (estado == FIM);
  assign bus.gravando    = (estado == ESPERA) || (estado == REGISTRA) ||
                           (estado == GRAVA)  || (estado == PROXIMO);
  assign bus.escreve     = escreve;
  assign bus.db_endereco = endereco;
  assign bus.db_dado     = dado;
  assign bus.db_estado   = estado;
endmodule

// File: tb/tb_gravador_sequencia.sv
// Scoreboarded bench for gravador_sequencia: presses queue the expected write,
// a negedge monitor pops and compares whenever escreve is high.
module tb_gravador_sequencia;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  gravador_sequencia_if #(.LARGURA(4)) bus ();

  gravador_sequencia #(.N_ENDERECOS(16), .LARGURA(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [3:0] endereco;
    logic [3:0] dado;
  } escrita_t;

  escrita_t   exp_q [$];
  escrita_t   vista;
  int         n_vec      = 0;
  int         n_err      = 0;
  int         n_escritas = 0;
  logic [3:0] modelo [16];
  logic [3:0] exp_end;

  task automatic check(input string nome, input logic [31:0] obtido, input logic [31:0] esperado);
    n_vec++;
    if (obtido !== esperado) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nome, obtido, esperado, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every escreve cycle must match the oldest queued write.
  always @(negedge clock) begin
    if (bus.escreve === 1'b1) begin
      n_escritas++;
      check("sb_write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        vista = exp_q.pop_front();
        check("sb_endereco", 32'(bus.db_endereco), 32'(vista.endereco));
        check("sb_dado", 32'(bus.db_dado), 32'(vista.dado));
      end
    end
  end

  task automatic iniciar_sessao();
    bus.iniciar = 1'b1;
    tick();
    check("start_preparacao", 32'(bus.db_estado), 32'h1);
    bus.iniciar = 1'b0;
    tick();
    check("start_espera", 32'(bus.db_estado), 32'h2);
    check("start_endereco", 32'(bus.db_endereco), 32'h0);
    check("start_gravando", 32'(bus.gravando), 32'h1);
    exp_end = 4'h0;
  endtask

  task automatic pressiona(input logic [3:0] v);
    bus.chaves = v;
    bus.jogada = 1'b1;
    if (v != 4'h0) begin
      exp_q.push_back('{endereco: exp_end, dado: v});
      modelo[exp_end] = v;
    end
    tick();
    bus.jogada = 1'b0;
    repeat (3) tick();
    if (v != 4'h0 && exp_end != 4'hF) exp_end = exp_end + 4'h1;
  endtask

  task automatic confere_ram(input int ultimo);
    for (int i = 0; i <= ultimo; i++) begin
      bus.ler_endereco = 4'(i);
      #1;
      check($sformatf("leitura_%0d", i), 32'(bus.dado_lido), 32'(modelo[i]));
    end
  endtask

  initial begin
    logic [3:0] padrao;
    bus.iniciar      = 1'b0;
    bus.jogada       = 1'b0;
    bus.chaves       = 4'h0;
    bus.ler_endereco = 4'h0;
    exp_end          = 4'h0;

    // Power-on reset
    repeat (2) tick();
    check("rst_estado", 32'(bus.db_estado), 32'h0);
    check("rst_pronto", 32'(bus.pronto), 32'h0);
    check("rst_gravando", 32'(bus.gravando), 32'h0);
    check("rst_escreve", 32'(bus.escreve), 32'h0);
    check("rst_endereco", 32'(bus.db_endereco), 32'h0);
    check("rst_dado", 32'(bus.db_dado), 32'h0);
    reset = 1'b1;
    tick();
    check("idle_inicial", 32'(bus.db_estado), 32'h0);

    // Session A: iniciar ignored in ESPERA, zero-value press filtered
    iniciar_sessao();
    bus.iniciar = 1'b1;
    tick();
    check("iniciar_ignored", 32'(bus.db_estado), 32'h2);
    bus.iniciar = 1'b0;
    pressiona(4'h0);
    check("zero_press_estado", 32'(bus.db_estado), 32'h2);
    check("zero_press_endereco", 32'(bus.db_endereco), 32'h0);
    pressiona(4'h7);
    pressiona(4'h3);
    pressiona(4'h9);
    pressiona(4'h4);

    // Long press: exactly one write, address advances by one
    bus.chaves = 4'h2;
    exp_q.push_back('{endereco: exp_end, dado: 4'h2});
    modelo[exp_end] = 4'h2;
    bus.jogada = 1'b1;
    repeat (20) tick();
    bus.jogada = 1'b0;
    repeat (4) tick();
    exp_end = exp_end + 4'h1;
    check("held_endereco", 32'(bus.db_endereco), 32'(exp_end));
    check("held_estado", 32'(bus.db_estado), 32'h2);
    check("held_writes", 32'(n_escritas), 32'd5);

    // Mid-session reset keeps RAM contents
    reset = 1'b0;
    repeat (2) tick();
    check("mid_rst_estado", 32'(bus.db_estado), 32'h0);
    check("mid_rst_endereco", 32'(bus.db_endereco), 32'h0);
    check("mid_rst_gravando", 32'(bus.gravando), 32'h0);
    bus.ler_endereco = 4'h3;
    #1;
    check("mid_rst_ram3", 32'(bus.dado_lido), 32'h4);
    confere_ram(4);
    reset = 1'b1;
    tick();

    // Full session of 16 presses overwriting from address 0
    iniciar_sessao();
    for (int i = 0; i < 16; i++) begin
      padrao = 4'(1 << (i % 4));
      if (i == 3) begin
        // Cycle-exact latency check, old value visible during GRAVA
        bus.ler_endereco = 4'h3;
        bus.chaves = 4'h8;
        bus.jogada = 1'b1;
        exp_q.push_back('{endereco: exp_end, dado: 4'h8});
        modelo[exp_end] = 4'h8;
        tick();
        check("lat_registra", 32'(bus.db_estado), 32'h3);
        check("lat_registra_escreve", 32'(bus.escreve), 32'h0);
        bus.jogada = 1'b0;
        tick();
        check("lat_grava", 32'(bus.db_estado), 32'h4);
        check("lat_grava_escreve", 32'(bus.escreve), 32'h1);
        check("lat_grava_old", 32'(bus.dado_lido), 32'h4);
        bus.chaves = 4'hF;
        tick();
        check("lat_proximo_escreve", 32'(bus.escreve), 32'h0);
        check("lat_new_data", 32'(bus.dado_lido), 32'h8);
        tick();
        check("lat_espera", 32'(bus.db_estado), 32'h2);
        check("lat_endereco", 32'(bus.db_endereco), 32'h4);
        exp_end = exp_end + 4'h1;
      end else begin
        pressiona(padrao);
      end
    end
    check("fim_estado", 32'(bus.db_estado), 32'hF);
    check("fim_pronto", 32'(bus.pronto), 32'h1);
    check("fim_gravando", 32'(bus.gravando), 32'h0);
    check("fim_endereco", 32'(bus.db_endereco), 32'hF);
    check("fim_writes", 32'(n_escritas), 32'd21);
    confere_ram(15);

    // Restart from FIM
    bus.iniciar = 1'b1;
    tick();
    check("restart_preparacao", 32'(bus.db_estado), 32'h1);
    bus.iniciar = 1'b0;
    tick();
    check("restart_espera", 32'(bus.db_estado), 32'h2);
    check("restart_endereco", 32'(bus.db_endereco), 32'h0);
    check("restart_pronto", 32'(bus.pronto), 32'h0);
    bus.iniciar = 1'b1;
    tick();
    check("restart_iniciar_ignored", 32'(bus.db_estado), 32'h2);
    bus.iniciar = 1'b0;
    repeat (2) tick();

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("total_writes", 32'(n_escritas), 32'd21);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
